// File: rtl/mem_pkg.sv
// Shared sizing and entry type for the store buffer and its match finder.
package mem_pkg;

    localparam int SB_DEPTH_DEF = 4;
    localparam int SB_ADDR_W    = 32;
    localparam int SB_DATA_W    = 32;
    localparam int SB_PTR_W     = $clog2(SB_DEPTH_DEF);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match finder over the store buffer entries, scanning oldest to youngest.
// STORE_BUF_FWD_EN: when undefined only the hit flag is produced; hit_data_o is tied off.
module sb_match
    import mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_entry_t             entries_i [DEPTH],
    input  logic [DEPTH-1:0]      valid_i,
    input  logic [PTR_W-1:0]      head_i,
    input  logic [SB_ADDR_W-1:0]  ld_addr_i,
    output logic                  hit_o,
    output logic [SB_DATA_W-1:0]  hit_data_o
);

    logic [PTR_W-1:0] idx;

    // Later (younger) matches overwrite earlier ones, so the youngest wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx].addr == ld_addr_i)) begin
                hit_o = 1'b1;
`ifdef STORE_BUF_FWD_EN
                hit_data_o = entries_i[idx].data;
`endif
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-granular store buffer: queues stores, drains them on an idle memory port, serves loads.
// STORE_BUF_FWD_EN: defined forwards hit loads; undefined stalls hit loads until the match drains.
module store_buffer
    import mem_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH_DEF,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_rvalid_o,
    output logic [DATA_W-1:0] ld_rdata_o,
    input  logic              fence_req_i,
    output logic              fence_done_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic [ADDR_W-1:0] direccion_o,
    output logic [DATA_W-1:0] escritura_datos_o,
    input  logic [DATA_W-1:0] leer_datos_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t         entries_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ld_rvalid_q, ld_rvalid_d;
    logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;

    logic [DEPTH-1:0]  valid;
    logic              hit;
    logic [DATA_W-1:0] hit_data;
    logic              full, empty, drain_pri;
    logic              push, pop, ld_fire, ld_port;

    always_comb begin
        valid = '0;
        for (int s = 0; s < DEPTH; s++) begin
            valid[s] = CNT_W'(PTR_W'(s) - head_q) < count_q;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries_i  (entries_q),
        .valid_i    (valid),
        .head_i     (head_q),
        .ld_addr_i  (ld_addr_i),
        .hit_o      (hit),
        .hit_data_o (hit_data)
    );

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        // A full buffer or a pending fence hands the port to the drain.
        drain_pri = full || fence_req_i;
`ifdef STORE_BUF_FWD_EN
        ld_ready_o = hit || !(drain_pri && !empty);
`else
        ld_ready_o = !hit && !(drain_pri && !empty);
`endif
        ld_fire    = ld_valid_i && ld_ready_o;
        ld_port    = ld_fire && !hit;
        pop        = !empty && !ld_port;
        st_ready_o = !full && !fence_req_i;
        push       = st_valid_i && st_ready_o;

        MemWrite_o        = pop && !reset_i;
        MemRead_o         = ld_port && !reset_i;
        direccion_o       = '0;
        escritura_datos_o = '0;
        if (MemRead_o) begin
            direccion_o = ld_addr_i;
        end else if (MemWrite_o) begin
            direccion_o       = entries_q[head_q].addr;
            escritura_datos_o = entries_q[head_q].data;
        end

        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        ld_rvalid_d = ld_fire;
        ld_rdata_d  = ld_rdata_q;
        if (ld_fire) begin
`ifdef STORE_BUF_FWD_EN
            ld_rdata_d = hit ? hit_data : leer_datos_i;
`else
            ld_rdata_d = leer_datos_i;
`endif
        end

        fence_done_o = fence_req_i && empty;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ld_rvalid_q <= ld_rvalid_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

    // Entry storage needs no reset; the count alone decides what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[tail_q] <= '{addr: st_addr_i, data: st_data_i};
        end
    end

    assign ld_rvalid_o = ld_rvalid_q;
    assign ld_rdata_o  = ld_rdata_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a queue-based reference model checked every cycle.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid, st_ready;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_ready;
    logic [31:0] ld_addr;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        fence_req, fence_done;
    logic        MemWrite, MemRead;
    logic [31:0] direccion, escritura_datos, leer_datos;

    always #5 clk = ~clk;

    store_buffer dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .st_valid_i        (st_valid),
        .st_ready_o        (st_ready),
        .st_addr_i         (st_addr),
        .st_data_i         (st_data),
        .ld_valid_i        (ld_valid),
        .ld_ready_o        (ld_ready),
        .ld_addr_i         (ld_addr),
        .ld_rvalid_o       (ld_rvalid),
        .ld_rdata_o        (ld_rdata),
        .fence_req_i       (fence_req),
        .fence_done_o      (fence_done),
        .MemWrite_o        (MemWrite),
        .MemRead_o         (MemRead),
        .direccion_o       (direccion),
        .escritura_datos_o (escritura_datos),
        .leer_datos_i      (leer_datos)
    );

    // Environment memory, written by the DUT.
    logic [31:0] mem [256];
    assign leer_datos = mem[direccion[7:0]];
    always @(posedge clk) if (MemWrite) mem[direccion[7:0]] <= escritura_datos;

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer as an ordered list, memory as a plain array.
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t        sbq[$];
    logic [31:0] ref_mem [256];
    bit          m_rvalid = 1'b0;
    logic [31:0] m_rdata  = '0;
    bit          model_on = 1'b0;

    always @(negedge clk) begin : cmp
        bit          hit, full, blk, rdy, fire, port, drain, st_rdy;
        logic [31:0] hd;
        int          n;
        ent_t        e;
        if (model_on) begin
            n    = sbq.size();
            full = (n == DEPTH);
            hit  = 1'b0;
            hd   = '0;
            foreach (sbq[i]) if (sbq[i].a == ld_addr) begin hit = 1'b1; hd = sbq[i].d; end
            blk = (full || fence_req) && (n > 0);
`ifdef STORE_BUF_FWD_EN
            rdy = hit || !blk;
`else
            rdy = !hit && !blk;
`endif
            fire   = ld_valid && rdy;
            port   = fire && !hit;
            drain  = (n > 0) && !port;
            st_rdy = !full && !fence_req;

            chk("st_ready", st_ready, st_rdy);
            chk("ld_ready", ld_ready, rdy);
            chk("fence_done", fence_done, fence_req && n == 0);
            chk("MemWrite", MemWrite, drain && !reset);
            chk("MemRead", MemRead, port && !reset);
            chk("direccion", direccion,
                reset ? 32'h0 : port ? ld_addr : drain ? sbq[0].a : 32'h0);
            chk("escritura_datos", escritura_datos,
                (!reset && !port && drain) ? sbq[0].d : 32'h0);
            chk("ld_rvalid", ld_rvalid, m_rvalid);
            if (m_rvalid) chk("ld_rdata", ld_rdata, m_rdata);

            if (reset) begin
                sbq.delete();
                m_rvalid = 1'b0;
                m_rdata  = '0;
            end else begin
                if (fire) m_rdata = hit ? hd : ref_mem[ld_addr[7:0]];
                m_rvalid = fire;
                if (drain) begin
                    ref_mem[sbq[0].a[7:0]] = sbq[0].d;
                    void'(sbq.pop_front());
                end
                if (st_valid && st_rdy) begin
                    e.a = st_addr;
                    e.d = st_data;
                    sbq.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        st_valid = 0; ld_valid = 0; fence_req = 0; st_addr = 0; st_data = 0; ld_addr = 0;
        repeat (n) tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input string nm,
                           output bit mr_at_acc);
        bit acc;
        acc       = 1'b0;
        mr_at_acc = 1'b0;
        ld_valid  = 1'b1;
        ld_addr   = a;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc       = ld_ready;
            mr_at_acc = MemRead;
            tick();
        end
        ld_valid = 1'b0;
        ld_addr  = '0;
        chk({nm, "_accepted"}, 32'(acc), 32'h1);
        chk({nm, "_rvalid"}, 32'(ld_rvalid), 32'h1);
        chk({nm, "_rdata"}, ld_rdata, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit mr;
        int writes;
        for (int i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        mem[8'h30]     = 32'd9;
        ref_mem[8'h30] = 32'd9;
        reset = 1; st_valid = 0; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0; fence_req = 0;
        tick();
        model_on = 1'b1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("rst_rvalid", 32'(ld_rvalid), 32'h0);
        chk("rst_rdata", ld_rdata, 32'h0);
        chk("rst_st_ready", 32'(st_ready), 32'h1);
        chk("rst_memwrite", 32'(MemWrite), 32'h0);
        tick();

        // 1: store then load the same address
        st_valid = 1; st_addr = 32'h10; st_data = 32'hDEADBEEF;
        tick();
        st_valid = 0;
        do_load(32'h10, 32'hDEADBEEF, "t1", mr);
`ifdef STORE_BUF_FWD_EN
        chk("t1_memread_at_accept", 32'(mr), 32'h0);
`else
        chk("t1_memread_at_accept", 32'(mr), 32'h1);
`endif
        idle(4);

        // 2: two stores to one address held in the buffer by miss loads
        ld_valid = 1; ld_addr = 32'h44;
        st_valid = 1; st_addr = 32'h20; st_data = 32'd1;
        tick();
        st_data = 32'd2;
        tick();
        st_valid = 0;
        do_load(32'h20, 32'd2, "t2", mr);
        idle(6);
        chk("t2_mem", mem[8'h20], 32'd2);

        // 3: fill to full while misses hold the port
        ld_valid = 1; ld_addr = 32'h48;
        for (int k = 0; k < 4; k++) begin
            st_valid = 1; st_addr = 32'h50 + 32'(4 * k); st_data = 32'h100 + 32'(k);
            tick();
        end
        st_addr = 32'h60; st_data = 32'h1FF;
        @(negedge clk);
        chk("t3_full_st_ready", 32'(st_ready), 32'h0);
        chk("t3_full_ld_ready", 32'(ld_ready), 32'h0);
        chk("t3_full_memwrite", 32'(MemWrite), 32'h1);
        chk("t3_full_dir", direccion, 32'h50);
        tick();
        @(negedge clk);
        chk("t3_after_ld_ready", 32'(ld_ready), 32'h1);
        chk("t3_after_st_ready", 32'(st_ready), 32'h1);
        tick();
        idle(8);
        chk("t3_mem5c", mem[8'h5C], 32'h103);
        chk("t3_mem60", mem[8'h60], 32'h1FF);

        // 4: reset during the first drain cycle
        ld_valid = 1; ld_addr = 32'h48;
        for (int k = 0; k < 3; k++) begin
            st_valid = 1; st_addr = 32'h70 + 32'(4 * k); st_data = 32'h111 * 32'(k + 1);
            tick();
        end
        st_valid = 0; ld_valid = 0; reset = 1;
        @(negedge clk);
        chk("t4_memwrite_in_reset", 32'(MemWrite), 32'h0);
        tick();
        reset = 0;
        @(negedge clk);
        chk("t4_memwrite_after", 32'(MemWrite), 32'h0);
        chk("t4_rvalid_after", 32'(ld_rvalid), 32'h0);
        idle(4);
        chk("t4_mem70", mem[8'h70], 32'h0);
        chk("t4_mem78", mem[8'h78], 32'h0);

        // 5: fence drains two entries
        ld_valid = 1; ld_addr = 32'h48;
        st_valid = 1; st_addr = 32'h80; st_data = 32'hA;
        tick();
        st_addr = 32'h84; st_data = 32'hB;
        tick();
        ld_valid = 0; st_addr = 32'h88; st_data = 32'hC; fence_req = 1;
        writes = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (MemWrite) writes++;
            if (c == 0) chk("t5_st_ready", 32'(st_ready), 32'h0);
            if (c < 2) chk("t5_fence_done_early", 32'(fence_done), 32'h0);
            if (c == 2) chk("t5_fence_done", 32'(fence_done), 32'h1);
            tick();
        end
        chk("t5_writes", 32'(writes), 32'd2);
        idle(4);
        chk("t5_mem84", mem[8'h84], 32'hB);
        chk("t5_mem88", mem[8'h88], 32'h0);

        // 6: store and load to one address in the same cycle
        st_valid = 1; st_addr = 32'h30; st_data = 32'd5;
        ld_valid = 1; ld_addr = 32'h30;
        @(negedge clk);
        chk("t6_ld_ready", 32'(ld_ready), 32'h1);
        chk("t6_memread", 32'(MemRead), 32'h1);
        tick();
        st_valid = 0; ld_valid = 0;
        chk("t6_rvalid", 32'(ld_rvalid), 32'h1);
        chk("t6_rdata", ld_rdata, 32'd9);
        idle(4);
        chk("t6_mem30", mem[8'h30], 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
